// File: rtl/imem_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit_if
//
// Bundles the fetch request/response handshake, the flush control, the
// program-load write port and the Busy status of imem_fetch_unit.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. The producer holds valid and its payload stable until that edge.
//   Ready may depend combinationally on the consumer's state and the other
//   control inputs, but valid never depends combinationally on ready.
//   Request channel : ReqValid/ReqReady, payload ReqAddr (fetch side -> memory)
//   Response channel: RespValid/RespReady, payload RespData/RespFault
//                     (memory -> decode side)
//
// Modports:
//   master - the fetch/decode side driving requests, flush and loads
//   slave  - the instruction memory itself
// -----------------------------------------------------------------------------
interface imem_fetch_unit_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int LOAD_AW = 8
);
    // Request channel
    logic                ReqValid;
    logic                ReqReady;
    logic [ADDR_W-1:0]   ReqAddr;

    // Response channel
    logic                RespValid;
    logic                RespReady;
    logic [DATA_W-1:0]   RespData;
    logic [1:0]          RespFault;

    // Control and status
    logic                Flush;
    logic                Busy;

    // Program-load write port
    logic                LoadEn;
    logic [LOAD_AW-1:0]  LoadAddr;
    logic [DATA_W-1:0]   LoadData;

    modport master (
        output ReqValid,
        output ReqAddr,
        output RespReady,
        output Flush,
        output LoadEn,
        output LoadAddr,
        output LoadData,
        input  ReqReady,
        input  RespValid,
        input  RespData,
        input  RespFault,
        input  Busy
    );

    modport slave (
        input  ReqValid,
        input  ReqAddr,
        input  RespReady,
        input  Flush,
        input  LoadEn,
        input  LoadAddr,
        input  LoadData,
        output ReqReady,
        output RespValid,
        output RespData,
        output RespFault,
        output Busy
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit
//
// Synchronous, loadable instruction memory with a request/response fetch
// handshake and a fixed multi-cycle read latency. Sits between the PC/fetch
// stage and decode. Misaligned or out-of-range fetches return NOP_WORD with a
// fault code instead of undefined data.
//
// Parameters:
//   DATA_W   - instruction word width
//   ADDR_W   - byte-address width of fetch requests (>= clog2(DEPTH)+2)
//   DEPTH    - number of words, power of two, 2..65536
//   LATENCY  - cycles from request acceptance to response, 1..15
//   NOP_WORD - data returned with a faulted fetch
//
// Ports:
//   CLK         - system clock, rising edge
//   Reset_L     - asynchronous active-low reset
//   bus         - imem_fetch_unit_if.slave:
//                   ReqValid/ReqReady/ReqAddr      fetch request
//                   RespValid/RespReady/RespData/RespFault  fetch response
//                     RespFault: 00 ok, 01 misaligned, 10 out of range
//                   Flush                          cancel outstanding fetch
//                   LoadEn/LoadAddr/LoadData       program-load write
//                   Busy                           fetch outstanding
//   dbg_state_o - current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// -----------------------------------------------------------------------------
module imem_fetch_unit #(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 32,
    parameter int              DEPTH    = 256,
    parameter int              LATENCY  = 2,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                CLK,
    input  logic                Reset_L,
    imem_fetch_unit_if.slave    bus,
    output logic [1:0]          dbg_state_o
);

    localparam int IDX_W = $clog2(DEPTH);

    // Wait counter is preloaded with LATENCY-1 so that the capture happens on
    // the LATENCY-th edge after acceptance.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Storage (not reset; contents are undefined until loaded)
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [1:0]         fault_q, fault_d;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic               req_ready;
    logic               accept;
    logic               misaligned;
    logic               out_of_range;
    logic [IDX_W-1:0]   word_idx;
    logic [DATA_W-1:0]  cap_data;
    logic [1:0]         cap_fault;

    assign misaligned = (addr_q[1:0] != 2'b00);
    assign word_idx   = addr_q[IDX_W+1:2];

    // The word index is out of range exactly when any address bit above the
    // index field is set, because DEPTH is a power of two.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_range_hi
            assign out_of_range = |addr_q[ADDR_W-1:IDX_W+2];
        end else begin : g_range_none
            assign out_of_range = 1'b0;
        end
    endgenerate

    // Result that would be captured this cycle. Misalignment takes priority
    // over range. The array read here sees the contents before any load
    // landing on the same edge (read-before-write).
    always_comb begin
        cap_data  = NOP_WORD;
        cap_fault = FAULT_OK;
        if (misaligned) begin
            cap_fault = FAULT_ALIGN;
        end else if (out_of_range) begin
            cap_fault = FAULT_RANGE;
        end else begin
            cap_data  = mem[word_idx];
        end
    end

    // A new request is taken when idle, or when the presented response is
    // being consumed in the same cycle. Loads and flushes block acceptance.
    assign req_ready = ((state_q == S_IDLE) ||
                        ((state_q == S_RESP) && bus.RespReady)) &&
                       !bus.LoadEn && !bus.Flush;
    assign accept    = bus.ReqValid && req_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        fault_d = fault_q;

        if (bus.Flush) begin
            // Flush beats RespReady and new requests; any pending or presented
            // response is dropped.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_d = S_RESP;
                        data_d  = cap_data;
                        fault_d = cap_fault;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.RespReady) begin
                        state_d = accept ? S_WAIT : S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // accept is already gated by Flush, so this cannot fight the flush.
        if (accept) begin
            addr_d = bus.ReqAddr;
            cnt_d  = CNT_INIT;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= '0;
            fault_q <= FAULT_OK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    // Program-load port: writes in any state.
    always_ff @(posedge CLK) begin
        if (bus.LoadEn) begin
            mem[bus.LoadAddr] <= bus.LoadData;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (RespValid comes straight from the state register)
    // -------------------------------------------------------------------------
    assign bus.ReqReady  = req_ready;
    assign bus.RespValid = (state_q == S_RESP);
    assign bus.RespData  = data_q;
    assign bus.RespFault = fault_q;
    assign bus.Busy      = (state_q != S_IDLE);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_unit
//
// Directed and randomized checks of imem_fetch_unit against a reference model
// that computes each fetch result from the memory image and address rules.
// -----------------------------------------------------------------------------
module tb_imem_fetch_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;
    localparam int LAT    = 2;
    localparam int IDX_W  = 8;
    localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

    // ---------------------------------------------------------------- clock/reset
    logic CLK     = 1'b0;
    logic Reset_L = 1'b0;
    logic [1:0] dbg_state;

    always #5 CLK = ~CLK;

    imem_fetch_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOAD_AW(IDX_W)) bus ();

    imem_fetch_unit #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LAT),
        .NOP_WORD(NOP)
    ) dut (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W+1:0] exp_q [$];   // {fault, data}

    // Expected response for a byte address, from the current memory image.
    function automatic logic [DATA_W+1:0] ref_fetch(input logic [ADDR_W-1:0] a);
        longint unsigned ua;
        ua = longint'(a);
        if (ua % 4 != 0)            return {2'b01, NOP};
        if (ua / 4 >= DEPTH)        return {2'b10, NOP};
        return {2'b00, ref_mem[int'(ua / 4)]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic tick();
        @(posedge CLK);
        cycle++;
        #1;
    endtask

    task automatic load_word(input int idx, input logic [DATA_W-1:0] d);
        bus.LoadEn   = 1'b1;
        bus.LoadAddr = IDX_W'(idx);
        bus.LoadData = d;
        tick();
        bus.LoadEn   = 1'b0;
        ref_mem[idx] = d;
    endtask

    // Present one request and let it be accepted on the next edge.
    task automatic issue(input logic [ADDR_W-1:0] a, input string tag);
        bus.ReqValid = 1'b1;
        bus.ReqAddr  = a;
        #1;
        chk($sformatf("%s_reqready", tag), 64'(bus.ReqReady), 64'd1);
        tick();
        bus.ReqValid = 1'b0;
        bus.ReqAddr  = $urandom();  // request address must have been latched
    endtask

    // Wait (bounded) for RespValid; n counts edges waited.
    task automatic wait_resp(output int n);
        n = 0;
        while (!bus.RespValid && n < 50) begin
            tick();
            n++;
        end
    endtask

    // Full fetch: accept, check latency and result, optionally stall, consume.
    task automatic fetch_check(input logic [ADDR_W-1:0] a, input string tag, input int hold);
        logic [DATA_W+1:0] e;
        int n;
        bit stable;
        issue(a, tag);
        e = ref_fetch(a);
        wait_resp(n);
        chk($sformatf("%s_latency", tag), 64'(n), 64'(LAT));
        chk($sformatf("%s_resp", tag), 64'({bus.RespFault, bus.RespData}), 64'(e));
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!(bus.RespValid === 1'b1 && {bus.RespFault, bus.RespData} === e))
                stable = 1'b0;
        end
        if (hold > 0) chk($sformatf("%s_stall", tag), 64'(stable), 64'd1);
        bus.RespReady = 1'b1;
        tick();
        bus.RespReady = 1'b0;
        chk($sformatf("%s_done", tag), 64'({bus.RespValid, bus.Busy}), 64'd0);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [ADDR_W-1:0] addrs [4];
        logic [DATA_W+1:0] e;
        logic [DATA_W-1:0] held;
        int n, issued, got, last, guard, kind;
        bit seen;

        bus.ReqValid  = 1'b0;
        bus.ReqAddr   = '0;
        bus.RespReady = 1'b0;
        bus.Flush     = 1'b0;
        bus.LoadEn    = 1'b0;
        bus.LoadAddr  = '0;
        bus.LoadData  = '0;

        // Reset state
        #1;
        chk("rst_respvalid", 64'(bus.RespValid), 64'd0);
        chk("rst_respdata",  64'(bus.RespData),  64'd0);
        chk("rst_respfault", 64'(bus.RespFault), 64'd0);
        chk("rst_busy",      64'(bus.Busy),      64'd0);
        chk("rst_reqready",  64'(bus.ReqReady),  64'd1);
        tick();
        tick();
        Reset_L = 1'b1;
        tick();

        // Load blocks ReqReady
        bus.LoadEn = 1'b1;
        #1;
        chk("load_blocks_ready", 64'(bus.ReqReady), 64'd0);
        bus.LoadEn = 1'b0;

        // Random image, then the program words at 0..3
        for (int i = 0; i < DEPTH; i++) load_word(i, $urandom());
        load_word(0, 32'h34080032);
        load_word(1, 32'hac080000);
        load_word(2, 32'h34080028);
        load_word(3, 32'hac080004);

        fetch_check(32'h0, "fetch0", 0);

        // Back-to-back with RespReady held high
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'hC;
        bus.RespReady = 1'b1;
        issued = 0; got = 0; last = 0; guard = 0;
        while (got < 4 && guard < 60) begin
            bus.ReqValid = (issued < 4);
            if (issued < 4) bus.ReqAddr = addrs[issued];
            #1;
            if (bus.RespValid) begin
                e = exp_q.pop_front();
                chk($sformatf("b2b_resp%0d", got), 64'({bus.RespFault, bus.RespData}), 64'(e));
                if (got > 0) chk($sformatf("b2b_gap%0d", got), 64'(cycle - last), 64'(LAT + 1));
                last = cycle;
                got++;
            end
            if (bus.ReqValid && bus.ReqReady) begin
                exp_q.push_back(ref_fetch(bus.ReqAddr));
                issued++;
            end
            tick();
            guard++;
        end
        bus.ReqValid  = 1'b0;
        bus.RespReady = 1'b0;
        chk("b2b_count", 64'(got), 64'd4);
        tick();

        // Fault cases
        fetch_check(32'h6,   "mis6",   0);
        fetch_check(32'h400, "oor400", 0);
        fetch_check(32'h402, "both402", 0);

        // Load during the first WAIT cycle is visible
        issue(32'h8, "ldwait");
        load_word(2, 32'hDEADBEEF);
        e = ref_fetch(32'h8);
        wait_resp(n);
        chk("ldwait_latency", 64'(n + 1), 64'(LAT));
        chk("ldwait_resp", 64'({bus.RespFault, bus.RespData}), 64'(e));
        bus.RespReady = 1'b1; tick(); bus.RespReady = 1'b0;

        // Load in the capture cycle is not visible
        issue(32'h8, "ldcap");
        e = ref_fetch(32'h8);
        tick();
        load_word(2, 32'h12345678);
        chk("ldcap_valid", 64'(bus.RespValid), 64'd1);
        chk("ldcap_resp", 64'({bus.RespFault, bus.RespData}), 64'(e));
        bus.RespReady = 1'b1; tick(); bus.RespReady = 1'b0;
        fetch_check(32'h8, "ldcap_after", 0);

        // Stall 5 cycles, then flush the presented response
        issue(32'h4, "stall");
        e = ref_fetch(32'h4);
        wait_resp(n);
        held = bus.RespData;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_valid%0d", i), 64'(bus.RespValid), 64'd1);
            chk($sformatf("stall_data%0d", i), 64'({bus.RespFault, bus.RespData}), 64'(e));
        end
        chk("stall_held", 64'(bus.RespData), 64'(held));
        bus.Flush = 1'b1;
        bus.RespReady = 1'b1;
        bus.ReqValid = 1'b1;
        #1;
        chk("flush_blocks_ready", 64'(bus.ReqReady), 64'd0);
        tick();
        bus.Flush = 1'b0; bus.RespReady = 1'b0; bus.ReqValid = 1'b0;
        #1;
        chk("flush_respvalid", 64'(bus.RespValid), 64'd0);
        chk("flush_busy",      64'(bus.Busy),      64'd0);
        chk("flush_reqready",  64'(bus.ReqReady),  64'd1);

        // Flush during WAIT: no response ever appears
        issue(32'hC, "flushwait");
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.RespValid) seen = 1'b1;
            tick();
        end
        chk("flushwait_noresp", 64'(seen), 64'd0);

        // Randomized fetches with random stalls
        for (int t = 0; t < 30; t++) begin
            logic [ADDR_W-1:0] a;
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1: a = ADDR_W'($urandom_range(0, DEPTH - 1) * 4);
                2:    a = ADDR_W'($urandom_range(0, DEPTH * 4 - 1) | 1);
                default: a = ADDR_W'($urandom_range(DEPTH, 1 << 20) * 4);
            endcase
            if ($urandom_range(0, 3) == 0) load_word($urandom_range(0, DEPTH - 1), $urandom());
            fetch_check(a, $sformatf("rnd%0d", t), $urandom_range(0, 3));
        end

        // Asynchronous reset mid-fetch
        fetch_check(32'h0, "prerst", 0);
        issue(32'h4, "rstwait");
        tick();
        Reset_L = 1'b0;
        #1;
        chk("arst_respvalid", 64'(bus.RespValid), 64'd0);
        chk("arst_respdata",  64'(bus.RespData),  64'd0);
        chk("arst_respfault", 64'(bus.RespFault), 64'd0);
        chk("arst_busy",      64'(bus.Busy),      64'd0);
        chk("arst_reqready",  64'(bus.ReqReady),  64'd1);
        tick();
        #2;
        Reset_L = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.RespValid) seen = 1'b1;
        end
        chk("arst_noresp", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
